// File: rtl/top_day13.sv
// top_day13: 5-stage in-order pipeline (IF/ID/EX/MEM/WB) running a fixed 16-word ROM program.
// Define FORWARDING_EN to enable EX-stage bypassing; otherwise every RAW hazard stalls until WB.
module top_day13 (
    input  logic       clk,
    input  logic       rstn,
    output logic [7:0] pc,
    output logic [7:0] alu_out
);
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_OR   = 4'd5;
    localparam logic [3:0] OP_LD   = 4'd6;
    localparam logic [3:0] OP_ST   = 4'd7;

    logic [15:0] if_id_instr;
    logic [3:0]  id_ex_op;
    logic [1:0]  id_ex_rd;
    logic [7:0]  id_ex_imm, id_ex_a, id_ex_b, id_ex_d;
`ifdef FORWARDING_EN
    logic [1:0]  id_ex_rs, id_ex_rt;
`endif
    logic [3:0]  ex_mem_op;
    logic [1:0]  ex_mem_rd;
    logic [7:0]  ex_mem_st;
    logic        mem_wb_wr;
    logic [1:0]  mem_wb_rd;
    logic [7:0]  mem_wb_val;
    logic [7:0]  rf   [4];
    logic [7:0]  dmem [16];

    logic [3:0]  id_op;
    logic [1:0]  id_rd, id_rs, id_rt;
    logic [7:0]  id_a, id_b, id_d;
    logic        stall;
    logic [7:0]  ex_a, ex_b, ex_d, ex_result;

    function automatic logic [15:0] rom_word(input logic [3:0] addr);
        case (addr)
            4'd0:    rom_word = {OP_ADDI, 2'd1, 2'd0, 8'd5};
            4'd1:    rom_word = {OP_ADDI, 2'd2, 2'd1, 8'd3};
            4'd2:    rom_word = {OP_ADD,  2'd3, 2'd1, 8'd2};
            4'd3:    rom_word = {OP_ST,   2'd3, 2'd0, 8'd0};
            4'd4:    rom_word = {OP_LD,   2'd1, 2'd0, 8'd0};
            4'd5:    rom_word = {OP_SUB,  2'd2, 2'd1, 8'd2};
            4'd6:    rom_word = {OP_ADDI, 2'd3, 2'd2, 8'd1};
            default: rom_word = 16'h0000;
        endcase
    endfunction

    function automatic logic writes_reg(input logic [3:0] op);
        writes_reg = (op >= OP_ADDI) && (op <= OP_LD);
    endfunction

    // True when an instruction with this op/fields consumes register w (never r0).
    function automatic logic reads_reg(input logic [3:0] op, input logic [1:0] rs,
                                       input logic [1:0] rt, input logic [1:0] rd,
                                       input logic [1:0] w);
        reads_reg = (w != 2'd0) &&
                    (((op >= OP_ADDI) && (op <= OP_ST) && (rs == w)) ||
                     ((op >= OP_ADD) && (op <= OP_OR) && (rt == w)) ||
                     ((op == OP_ST) && (rd == w)));
    endfunction

    assign id_op = if_id_instr[15] ? OP_NOP : if_id_instr[15:12];
    assign id_rd = if_id_instr[11:10];
    assign id_rs = if_id_instr[9:8];
    assign id_rt = if_id_instr[1:0];

    // Register reads see the value being written back in this same cycle.
    assign id_a = (id_rs == 2'd0) ? 8'd0 : (mem_wb_wr && mem_wb_rd == id_rs) ? mem_wb_val : rf[id_rs];
    assign id_b = (id_rt == 2'd0) ? 8'd0 : (mem_wb_wr && mem_wb_rd == id_rt) ? mem_wb_val : rf[id_rt];
    assign id_d = (id_rd == 2'd0) ? 8'd0 : (mem_wb_wr && mem_wb_rd == id_rd) ? mem_wb_val : rf[id_rd];

`ifdef FORWARDING_EN
    assign stall = (id_ex_op == OP_LD) && reads_reg(id_op, id_rs, id_rt, id_rd, id_ex_rd);

    always_comb begin
        ex_a = id_ex_a;
        ex_b = id_ex_b;
        ex_d = id_ex_d;
        if (writes_reg(ex_mem_op) && ex_mem_op != OP_LD && ex_mem_rd != 2'd0 && ex_mem_rd == id_ex_rs)
            ex_a = alu_out;
        else if (mem_wb_wr && mem_wb_rd == id_ex_rs)
            ex_a = mem_wb_val;
        if (writes_reg(ex_mem_op) && ex_mem_op != OP_LD && ex_mem_rd != 2'd0 && ex_mem_rd == id_ex_rt)
            ex_b = alu_out;
        else if (mem_wb_wr && mem_wb_rd == id_ex_rt)
            ex_b = mem_wb_val;
        if (writes_reg(ex_mem_op) && ex_mem_op != OP_LD && ex_mem_rd != 2'd0 && ex_mem_rd == id_ex_rd)
            ex_d = alu_out;
        else if (mem_wb_wr && mem_wb_rd == id_ex_rd)
            ex_d = mem_wb_val;
    end
`else
    assign stall = (writes_reg(id_ex_op) && reads_reg(id_op, id_rs, id_rt, id_rd, id_ex_rd)) ||
                   (writes_reg(ex_mem_op) && reads_reg(id_op, id_rs, id_rt, id_rd, ex_mem_rd));

    always_comb begin
        ex_a = id_ex_a;
        ex_b = id_ex_b;
        ex_d = id_ex_d;
    end
`endif

    always_comb begin
        ex_result = 8'd0;
        case (id_ex_op)
            OP_ADDI:      ex_result = ex_a + id_ex_imm;
            OP_ADD:       ex_result = ex_a + ex_b;
            OP_SUB:       ex_result = ex_a - ex_b;
            OP_AND:       ex_result = ex_a & ex_b;
            OP_OR:        ex_result = ex_a | ex_b;
            OP_LD, OP_ST: ex_result = {4'd0, ex_a[3:0] + id_ex_imm[3:0]};
            default:      ex_result = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc          <= 8'd0;
            if_id_instr <= 16'h0000;
        end else if (!stall) begin
            pc          <= pc + 8'd1;
            if_id_instr <= (pc < 8'd16) ? rom_word(pc[3:0]) : 16'h0000;
        end
    end

    // A stall injects a bubble (NOP) into EX while IF/ID holds.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || stall) begin
            id_ex_op  <= OP_NOP;
            id_ex_rd  <= 2'd0;
            id_ex_imm <= 8'd0;
            id_ex_a   <= 8'd0;
            id_ex_b   <= 8'd0;
            id_ex_d   <= 8'd0;
        end else begin
            id_ex_op  <= id_op;
            id_ex_rd  <= id_rd;
            id_ex_imm <= if_id_instr[7:0];
            id_ex_a   <= id_a;
            id_ex_b   <= id_b;
            id_ex_d   <= id_d;
        end
    end

`ifdef FORWARDING_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn || stall) begin
            id_ex_rs <= 2'd0;
            id_ex_rt <= 2'd0;
        end else begin
            id_ex_rs <= id_rs;
            id_ex_rt <= id_rt;
        end
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ex_mem_op  <= OP_NOP;
            ex_mem_rd  <= 2'd0;
            ex_mem_st  <= 8'd0;
            alu_out    <= 8'd0;
            mem_wb_wr  <= 1'b0;
            mem_wb_rd  <= 2'd0;
            mem_wb_val <= 8'd0;
        end else begin
            ex_mem_op  <= id_ex_op;
            ex_mem_rd  <= id_ex_rd;
            ex_mem_st  <= ex_d;
            alu_out    <= ex_result;
            mem_wb_wr  <= writes_reg(ex_mem_op) && (ex_mem_rd != 2'd0);
            mem_wb_rd  <= ex_mem_rd;
            mem_wb_val <= (ex_mem_op == OP_LD) ? dmem[alu_out[3:0]] : alu_out;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) dmem[i] <= 8'd0;
            for (int i = 0; i < 4; i++) rf[i] <= 8'd0;
        end else begin
            if (ex_mem_op == OP_ST) dmem[alu_out[3:0]] <= ex_mem_st;
            if (mem_wb_wr) rf[mem_wb_rd] <= mem_wb_val;
        end
    end
endmodule

// File: tb/tb_top_day13.sv
// tb_top_day13: self-checking bench for top_day13 using an instruction-level reference model.
// Exact per-edge timing is checked when FORWARDING_EN is defined; otherwise result order only.
module tb_top_day13;
    localparam int MAXE = 360;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic [7:0] pc, alu_out;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_alu [MAXE+1];
    logic [7:0] exp_pc  [MAXE+1];
    logic [7:0] exp_nz  [$];

    top_day13 dut (
        .clk    (clk),
        .rstn   (rstn),
        .pc     (pc),
        .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] prog_word(input logic [7:0] addr);
        case (addr)
            8'd0:    prog_word = 16'h1405;
            8'd1:    prog_word = 16'h1903;
            8'd2:    prog_word = 16'h2D02;
            8'd3:    prog_word = 16'h7C00;
            8'd4:    prog_word = 16'h6400;
            8'd5:    prog_word = 16'h3902;
            8'd6:    prog_word = 16'h1E01;
            default: prog_word = 16'h0000;
        endcase
    endfunction

    // Executes the program one instruction at a time and places each result on the edge
    // where it should appear: three edges after issue, plus one per load-use pair so far.
    task automatic build_model();
        logic [7:0]  regs [4];
        logic [7:0]  mem  [16];
        int          stall_at [MAXE+1];
        logic [15:0] instr;
        logic [3:0]  op;
        logic [1:0]  rd, rs, rt;
        logic [7:0]  imm, res, mpc;
        logic [3:0]  addr;
        logic        prev_ld, uses;
        logic [1:0]  prev_rd;
        int          stalls, edge_no, cum;
        for (int i = 0; i < 4; i++) regs[i] = 8'd0;
        for (int i = 0; i < 16; i++) mem[i] = 8'd0;
        for (int e = 0; e <= MAXE; e++) begin
            exp_alu[e] = 8'd0;
            stall_at[e] = 0;
        end
        exp_nz.delete();
        mpc = 8'd0; stalls = 0; prev_ld = 1'b0; prev_rd = 2'd0;
        for (int i = 0; i < MAXE; i++) begin
            instr = prog_word(mpc);
            op = instr[15:12]; rd = instr[11:10]; rs = instr[9:8]; rt = instr[1:0]; imm = instr[7:0];
            res = 8'd0;
            uses = 1'b0;
            if (op >= 4'd1 && op <= 4'd7 && rs == prev_rd) uses = 1'b1;
            if (op >= 4'd2 && op <= 4'd5 && rt == prev_rd) uses = 1'b1;
            if (op == 4'd7 && rd == prev_rd) uses = 1'b1;
            if (prev_ld && prev_rd != 2'd0 && uses) begin
                stalls++;
                if (i + 1 + stalls <= MAXE) stall_at[i + 1 + stalls] = 1;
            end
            case (op)
                4'd1: res = regs[rs] + imm;
                4'd2: res = regs[rs] + regs[rt];
                4'd3: res = regs[rs] - regs[rt];
                4'd4: res = regs[rs] & regs[rt];
                4'd5: res = regs[rs] | regs[rt];
                4'd6: begin
                    addr = regs[rs][3:0] + imm[3:0];
                    res = {4'd0, addr};
                end
                4'd7: begin
                    addr = regs[rs][3:0] + imm[3:0];
                    res = {4'd0, addr};
                    mem[addr] = regs[rd];
                end
                default: res = 8'd0;
            endcase
            if (op >= 4'd1 && op <= 4'd5 && rd != 2'd0) regs[rd] = res;
            if (op == 4'd6 && rd != 2'd0) regs[rd] = mem[res[3:0]];
            edge_no = i + 3 + stalls;
            if (edge_no <= MAXE) exp_alu[edge_no] = res;
            if (res != 8'd0) exp_nz.push_back(res);
            prev_ld = (op == 4'd6);
            prev_rd = rd;
            mpc = mpc + 8'd1;
        end
        cum = 0;
        for (int e = 0; e <= MAXE; e++) begin
            cum += stall_at[e];
            exp_pc[e] = 8'(e - cum);
        end
    endtask

    task automatic reset_and_release();
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Runs n edges after a reset release, comparing each sampled edge and the result order.
    task automatic run_program(input int n, input int min_nz);
        logic [7:0] dut_nz [$];
        logic [7:0] prev_pc;
        logic       wrapped;
        prev_pc = 8'd0;
        wrapped = 1'b0;
        for (int e = 1; e <= n; e++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ($isunknown({pc, alu_out})) begin
                errors++;
                $display("[TB] FAIL no_x edge %0d: pc=%h alu_out=%h, required known values", e, pc, alu_out);
            end
`ifdef FORWARDING_EN
            checks++;
            if (alu_out !== exp_alu[e]) begin
                errors++;
                $display("[TB] FAIL alu_out edge %0d: got %0d, expected %0d", e, alu_out, exp_alu[e]);
            end
            checks++;
            if (pc !== exp_pc[e]) begin
                errors++;
                $display("[TB] FAIL pc edge %0d: got %0d, expected %0d", e, pc, exp_pc[e]);
            end
`else
            if (e == 10) begin
                checks++;
                if (!(pc < 8'd9)) begin
                    errors++;
                    $display("[TB] FAIL pc_stalled edge 10: got %0d, expected below 9", pc);
                end
            end
`endif
            if (!$isunknown(alu_out) && alu_out != 8'd0) dut_nz.push_back(alu_out);
            if (prev_pc == 8'd255 && pc == 8'd0) wrapped = 1'b1;
            prev_pc = pc;
        end
        checks++;
        if (dut_nz.size() < min_nz) begin
            errors++;
            $display("[TB] FAIL result_count: got %0d nonzero results, expected at least %0d", dut_nz.size(), min_nz);
        end
        for (int k = 0; k < min_nz && k < dut_nz.size(); k++) begin
            checks++;
            if (dut_nz[k] !== exp_nz[k]) begin
                errors++;
                $display("[TB] FAIL result_seq[%0d]: got %0d, expected %0d", k, dut_nz[k], exp_nz[k]);
            end
        end
        if (n >= 300) begin
            checks++;
            if (!wrapped) begin
                errors++;
                $display("[TB] FAIL pc_wrap: got no 255->0 transition, expected one");
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (pc !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_pc: got %h, expected 00", pc);
        end
        checks++;
        if (alu_out !== 8'd0) begin
            errors++;
            $display("[TB] FAIL reset_alu: got %h, expected 00", alu_out);
        end
        rstn = 1'b1;
    endtask

    task automatic test_program();
        run_program(30, 5);
    endtask

    task automatic test_mid_reset();
        int k;
        for (int r = 0; r < 3; r++) begin
            k = $urandom_range(3, 40);
            repeat (k) @(posedge clk);
            #2 rstn = 1'b0;
            #1;
            checks++;
            if (pc !== 8'd0) begin
                errors++;
                $display("[TB] FAIL async_reset_pc after %0d edges: got %0d, expected 0", k, pc);
            end
            checks++;
            if (alu_out !== 8'd0) begin
                errors++;
                $display("[TB] FAIL async_reset_alu after %0d edges: got %0d, expected 0", k, alu_out);
            end
            repeat ($urandom_range(1, 3)) @(negedge clk);
            rstn = 1'b1;
            run_program(30, 5);
        end
    endtask

    task automatic test_wrap();
        reset_and_release();
        run_program(340, 10);
    endtask

    initial begin
        build_model();
        test_reset();
        test_program();
        test_mid_reset();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/top_day13.md
TOP_DAY13 -- requirements
Module: top_day13

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rstn  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: pc  output  8  current fetch program counter (registered).
REQ-004 SHALL have port: alu_out  output  8  EX/MEM pipeline-register ALU result (registered).

Function
REQ-005 SHALL implement a 5-stage in-order pipeline (IF, ID, EX, MEM, WB) with internal 16-entry x 16-bit instruction ROM, 4 x 8-bit register file (r0 reads 0, writes ignored), 16 x 8-bit data RAM.
REQ-006 SHALL decode the instruction word as: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm; rt = [1:0].
REQ-007 SHALL support ops: 0 NOP; 1 ADDI rd=rs+imm; 2 ADD rd=rs+rt; 3 SUB rd=rs-rt; 4 AND; 5 OR; 6 LD rd=dmem[(rs+imm)[3:0]]; 7 ST dmem[(rs+imm)[3:0]]=rd; ops 8-15 execute as NOP.
REQ-008 SHALL use modulo-256 arithmetic (no flags); alu_out for LD/ST = address; alu_out for NOP/bubble = 0.
REQ-009 SHALL fetch ROM[pc[3:0]] when pc<16, else NOP; pc increments by 1 per non-stalled cycle and wraps 255->0.
REQ-010 SHALL load ROM at elaboration with the default program: 0 ADDI r1,r0,5; 1 ADDI r2,r1,3; 2 ADD r3,r1,r2; 3 ST r3,[r0+0]; 4 LD r1,[r0+0]; 5 SUB r2,r1,r2; 6 ADDI r3,r2,1; 7-15 NOP.
REQ-011 SHALL forward to EX operands: EX/MEM result (non-load) takes priority over MEM/WB result; only for writing instructions with rd!=0; ST data operand (rd) forwarded likewise.
REQ-012 SHALL write the register file in WB with write-through: a read in ID of the register written in the same cycle returns the new value.
REQ-013 SHALL detect load-use: LD in EX with rd!=0 equal to a source (rs, rt, or ST rd) of the ID instruction -> hold pc and IF/ID, insert one bubble into ID/EX.
REQ-014 SHALL treat a bubble as NOP (no register/RAM write, alu_out 0).
REQ-015 SHALL never produce X on pc or alu_out after reset.

Reset
REQ-016 SHALL, while rstn=0, asynchronously clear pc, alu_out, all pipeline registers (to NOP/bubble), register file and data RAM to 0.
REQ-017 SHALL fetch ROM[0] on the first rising edge with rstn=1; reset asserted mid-program restarts from pc=0 with cleared state.

Configuration
REQ-018 SHALL use macro FORWARDING_EN: defined -> forwarding paths of REQ-011 active, only load-use stall of REQ-013.
REQ-019 SHALL, without FORWARDING_EN, omit forwarding and stall (hold pc/IF/ID, bubble ID/EX) while any ID source matches rd!=0 of a writing instruction in EX or MEM; architectural results SHALL be identical, only timing differs.

Verification
REQ-020 SHALL check, with FORWARDING_EN: after edges 3,4,5 post-reset alu_out = 5, 8, 13 (forwarding both operands).
REQ-021 SHALL check: after edges 6,7 alu_out = 0, 0 (ST/LD address 0); edge 7 holds pc=6 (load-use stall); edge 8 alu_out=0 (bubble).
REQ-022 SHALL check: after edges 9,10 alu_out = 5 then 6; pc=9 after 10 edges; no X on outputs.
REQ-023 SHALL check, without FORWARDING_EN: non-bubble alu_out sequence 5, 8, 13, 0, 0, 5, 6 identical, pc after 10 edges < 9.
REQ-024 SHALL check: rstn pulsed low mid-run -> pc and alu_out 0 immediately, sequence of REQ-020..022 repeats.
REQ-025 SHALL check: run 300 cycles -> pc wraps 255->0 and program re-executes with same alu_out sequence.
